adc_deshaper: RTL and testbench



---
 rtl/adc_deshaper_pkg.sv | 19 +
 rtl/adc_deshaper_accumulator.sv | 51 +++++
 rtl/adc_deshaper.sv | 150 +++++++++++++++
 tb/tb_adc_deshaper.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_deshaper_pkg.sv
// Shared types and constants for the ADC de-shaping front end.
package adc_deshaper_pkg;

  // Top-level operating modes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Rail codes of the 12-bit converter
  localparam int unsigned CODE_MIN = 0;
  localparam int unsigned CODE_MAX = 4095;

  // Rail-hit counter width and ceiling
  localparam int unsigned SAT_W = 16;
  localparam logic [SAT_W-1:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/adc_deshaper_accumulator.sv
// Averaging window for baseline calibration: sums 2^CAL_LOG samples and
// presents the truncated mean combinationally on the sample that closes the window.
module baseline_accumulator #(
  parameter int unsigned BITS_IN = 12,
  parameter int unsigned CAL_LOG = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               sample_en,
  input  logic [BITS_IN-1:0] sample,
  output logic               done_c,
  output logic [BITS_IN-1:0] mean_c
);

  localparam int unsigned ACC_W = BITS_IN + CAL_LOG;

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   acc_sum_c;
  logic [CAL_LOG-1:0] cnt_q;
  logic [CAL_LOG-1:0] cnt_d;

  // Running sum including the current sample; clear wins over a coincident sample
  always_comb begin
    acc_sum_c = acc_q + ACC_W'(sample);
    done_c    = sample_en && !clear && (cnt_q == '1);
    mean_c    = BITS_IN'(acc_sum_c >> CAL_LOG);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_en) begin
      acc_d = acc_sum_c;
      cnt_d = cnt_q + CAL_LOG'(1);
    end
  end

  // Accumulator and sample counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_deshaper.sv
// Converts unsigned ADC codes to the signed internal domain: baseline subtract,
// scale by 2^G_ENTRADA_LOG, flag and count rail codes. Baseline comes from an
// averaging calibration or a direct load.
module adc_deshaper
  import adc_deshaper_pkg::*;
#(
  parameter int unsigned BITS_IN       = 12,
  parameter int unsigned BITS_OUT      = 34,
  parameter int unsigned G_ENTRADA_LOG = 10,
  parameter int unsigned CAL_LOG       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [BITS_IN-1:0]         in,
  input  logic                       cal_start,
  input  logic                       baseline_load,
  input  logic [BITS_IN-1:0]         baseline_in,
  input  logic                       sat_clr,
  output logic                       out_valid,
  output logic signed [BITS_OUT-1:0] out,
  output logic                       out_sat,
  output logic [BITS_IN-1:0]         baseline,
  output logic                       cal_busy,
  output logic                       cal_done,
  output logic [SAT_W-1:0]           sat_count
);

  state_e                     state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [BITS_OUT-1:0] out_q, out_d;
  logic                       out_sat_q, out_sat_d;
  logic [BITS_IN-1:0]         baseline_q, baseline_d;
  logic                       cal_busy_q, cal_busy_d;
  logic                       cal_done_q, cal_done_d;
  logic [SAT_W-1:0]           sat_count_q, sat_count_d;

  logic                       acc_clear_c;
  logic                       acc_en_c;
  logic                       acc_done_c;
  logic [BITS_IN-1:0]         acc_mean_c;
  logic [BITS_IN:0]           diff_c;
  logic signed [BITS_OUT-1:0] shaped_c;
  logic                       rail_c;

  // Window restarts whenever we are not calibrating or a pulse redirects the FSM
  assign acc_clear_c = (state_q != CAL) || cal_start || baseline_load;
  assign acc_en_c    = (state_q == CAL) && in_valid;

  baseline_accumulator #(
    .BITS_IN (BITS_IN),
    .CAL_LOG (CAL_LOG)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear_c),
    .sample_en (acc_en_c),
    .sample    (in),
    .done_c    (acc_done_c),
    .mean_c    (acc_mean_c)
  );

  // Zero-extended difference fits in BITS_IN+1 signed bits, so no clipping is needed
  always_comb begin
    diff_c   = {1'b0, in} - {1'b0, baseline_q};
    shaped_c = BITS_OUT'($signed(diff_c)) <<< G_ENTRADA_LOG;
    rail_c   = (in == BITS_IN'(CODE_MIN)) || (in == BITS_IN'(CODE_MAX));
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    out_d       = out_q;
    out_sat_d   = out_sat_q;
    baseline_d  = baseline_q;
    cal_done_d  = 1'b0;
    sat_count_d = sat_count_q;

    unique case (state_q)
      IDLE: begin
        if (cal_start) state_d = CAL;
      end
      CAL: begin
        if (cal_start) begin
          state_d = CAL;
        end else if (acc_done_c) begin
          baseline_d = acc_mean_c;
          cal_done_d = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          out_d       = shaped_c;
          out_sat_d   = rail_c;
          if (rail_c && (sat_count_q != SAT_MAX)) begin
            sat_count_d = sat_count_q + SAT_W'(1);
          end
        end
        if (cal_start) state_d = CAL;
      end
      default: state_d = IDLE;
    endcase

    if (sat_clr) sat_count_d = '0;

    // Direct load overrides any calibration in progress and any coincident cal_start
    if (baseline_load) begin
      baseline_d = baseline_in;
      cal_done_d = 1'b0;
      state_d    = RUN;
    end

    cal_busy_d = (state_d == CAL);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sat_q   <= 1'b0;
      baseline_q  <= '0;
      cal_busy_q  <= 1'b0;
      cal_done_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_sat_q   <= out_sat_d;
      baseline_q  <= baseline_d;
      cal_busy_q  <= cal_busy_d;
      cal_done_q  <= cal_done_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_sat   = out_sat_q;
  assign baseline  = baseline_q;
  assign cal_busy  = cal_busy_q;
  assign cal_done  = cal_done_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_adc_deshaper.sv
// Self-checking bench for adc_deshaper: directed tables, hand sequences and a
// randomized RUN/calibration phase checked against an arithmetic reference.
module tb_adc_deshaper;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [11:0]        in_code;
  logic               cal_start;
  logic               baseline_load;
  logic [11:0]        baseline_in;
  logic               sat_clr;
  logic               out_valid;
  logic signed [33:0] out;
  logic               out_sat;
  logic [11:0]        baseline;
  logic               cal_busy;
  logic               cal_done;
  logic [15:0]        sat_count;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [11:0] code;
    longint      exp_out;
    logic        exp_sat;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[6];

  adc_deshaper dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in            (in_code),
    .cal_start     (cal_start),
    .baseline_load (baseline_load),
    .baseline_in   (baseline_in),
    .sat_clr       (sat_clr),
    .out_valid     (out_valid),
    .out           (out),
    .out_sat       (out_sat),
    .baseline      (baseline),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done),
    .sat_count     (sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // One clock with the given inputs; outputs are read 1ns after the edge
  task automatic drive(input logic v, input logic [11:0] code, input logic cs,
                       input logic bl, input logic sc);
    in_valid = v; in_code = code; cal_start = cs; baseline_load = bl; sat_clr = sc;
    @(posedge clk); #1;
    in_valid = 1'b0; cal_start = 1'b0; baseline_load = 1'b0; sat_clr = 1'b0;
  endtask

  function automatic longint ref_out(input int code, input int bl);
    return longint'(code - bl) * 1024;
  endfunction

  function automatic bit is_rail(input int code);
    return (code == 0) || (code == 4095);
  endfunction

  // Calibration with random gaps and values; optional restart after sample restart_at
  task automatic cal_gapped(input int restart_at, input string tag);
    int nv = 0; int cyc = 0; int bad = 0; longint sum = 0; bit restarted = 0;
    logic v; int code;
    drive(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    chk({tag, "_busy"}, cal_busy, 1);
    while (nv < 256 && cyc < 3000) begin
      v = ($urandom_range(0, 99) < 64);
      code = $urandom_range(0, 4095);
      drive(v, 12'(code), 1'b0, 1'b0, 1'b0);
      cyc++;
      if (v) begin nv++; sum += code; end
      if (cal_done && !(v && nv == 256)) bad++;
      if (out_valid) bad++;
      if (restart_at != 0 && !restarted && v && nv == restart_at) begin
        restarted = 1;
        drive(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
        cyc++;
        if (cal_done || !cal_busy) bad++;
        nv = 0; sum = 0;
      end
    end
    chk({tag, "_bound"}, nv, 256);
    chk({tag, "_gaps"}, (cyc > 256) ? 1 : 0, 1);
    chk({tag, "_done"}, cal_done, 1);
    chk({tag, "_spurious"}, bad, 0);
    chk({tag, "_baseline"}, baseline, sum >>> 8);
    chk({tag, "_busy_end"}, cal_busy, 0);
  endtask

  initial begin
    int bad; int bl; int cnt; longint last_out; logic v; logic sc; int code;

    vecs[0] = '{12'd0,    -64'sd4193280, 1'b1, 1};
    vecs[1] = '{12'd4095, 64'sd0,        1'b1, 2};
    vecs[2] = '{12'd2048, -64'sd2096128, 1'b0, 2};
    vecs[3] = '{12'd1,    -64'sd4192256, 1'b0, 2};
    vecs[4] = '{12'd4094, -64'sd1024,    1'b0, 2};
    vecs[5] = '{12'd0,    -64'sd4193280, 1'b1, 3};

    in_valid = 0; in_code = 0; cal_start = 0; baseline_load = 0;
    baseline_in = 0; sat_clr = 0; rst = 1'b0;
    drive(1'b1, 12'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_baseline", baseline, 0);
    chk("rst_cal_busy", cal_busy, 0);
    chk("rst_cal_done", cal_done, 0);
    chk("rst_sat_count", sat_count, 0);
    rst = 1'b1;

    // IDLE produces no output
    drive(1'b1, 12'd100, 1'b0, 1'b0, 1'b0);
    chk("idle_no_out", out_valid, 0);

    // Calibration on constant 2048
    drive(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    chk("cal1_busy", cal_busy, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 12'd2048, 1'b0, 1'b0, 1'b0);
      if (i < 255 && (cal_done || out_valid || !cal_busy)) bad++;
    end
    chk("cal1_early", bad, 0);
    chk("cal1_done", cal_done, 1);
    chk("cal1_baseline", baseline, 2048);
    chk("cal1_busy_end", cal_busy, 0);
    chk("cal1_no_out", out_valid, 0);
    drive(1'b1, 12'd2100, 1'b0, 1'b0, 1'b0);
    chk("run1_done_pulse", cal_done, 0);
    chk("run1_valid", out_valid, 1);
    chk("run1_out", out, 53248);
    chk("run1_sat", out_sat, 0);
    drive(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("run1_valid_pulse", out_valid, 0);
    chk("run1_hold", out, 53248);

    // Truncating mean: alternating 1000/1001
    drive(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) drive(1'b1, (i % 2) ? 12'd1001 : 12'd1000, 1'b0, 1'b0, 1'b0);
    chk("cal2_done", cal_done, 1);
    chk("cal2_baseline", baseline, 1000);
    drive(1'b1, 12'd999, 1'b0, 1'b0, 1'b0);
    chk("run2_out", out, -1024);
    chk("run2_sat_count", sat_count, 0);

    // Manual load of 4095 and rail vectors
    baseline_in = 12'd4095;
    drive(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
    chk("load_baseline", baseline, 4095);
    chk("load_busy", cal_busy, 0);
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].code, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      chk($sformatf("vec%0d_sat", i), out_sat, vecs[i].exp_sat);
      chk($sformatf("vec%0d_cnt", i), sat_count, vecs[i].exp_cnt);
    end

    // Load with coincident sample: sample uses old baseline
    baseline_in = 12'd0;
    drive(1'b1, 12'd100, 1'b0, 1'b1, 1'b0);
    chk("load_coinc_out", out, -4090880);
    chk("load_coinc_baseline", baseline, 0);

    // Gapped calibration, then gapped with restart at valid sample 100
    cal_gapped(0, "gap");
    cal_gapped(100, "gap_rst");

    // Load aborts a calibration with no cal_done
    drive(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) drive(1'b1, 12'd7, 1'b0, 1'b0, 1'b0);
    baseline_in = 12'd321;
    drive(1'b1, 12'd7, 1'b0, 1'b1, 1'b0);
    chk("abort_no_done", cal_done, 0);
    chk("abort_baseline", baseline, 321);
    chk("abort_busy", cal_busy, 0);

    // Randomized RUN phase against the reference model
    bl = $urandom_range(0, 4095);
    baseline_in = 12'(bl);
    drive(1'b0, 12'd0, 1'b0, 1'b1, 1'b1);
    cnt = 0; last_out = longint'(out);
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      sc = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 5))
        0: code = 0;
        1: code = 4095;
        default: code = $urandom_range(0, 4095);
      endcase
      drive(v, 12'(code), 1'b0, 1'b0, sc);
      if (v) last_out = ref_out(code, bl);
      if (sc) cnt = 0;
      else if (v && is_rail(code) && cnt < 65535) cnt++;
      if (out_valid !== v) bad++;
      if (longint'(out) != last_out) bad++;
      if (v && out_sat !== is_rail(code)) bad++;
      if (sat_count != 16'(cnt)) bad++;
      if (bad == 1) begin
        $display("FAIL rand_step%0d: got out=%0d sat=%0d cnt=%0d expected out=%0d cnt=%0d",
                 i, out, out_sat, sat_count, last_out, cnt);
        bad++;
      end
    end
    chk("rand_run_errors", bad, 0);

    // sat_count ceiling
    drive(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    chk("satclr_zero", sat_count, 0);
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, (i % 2) ? 12'd4095 : 12'd0, 1'b0, 1'b0, 1'b0);
      if (i == 65533) chk("sat_65534", sat_count, 65534);
      if (i == 65534) chk("sat_65535", sat_count, 65535);
    end
    chk("sat_hold", sat_count, 65535);
    drive(1'b1, 12'd0, 1'b0, 1'b0, 1'b1);
    chk("satclr_wins", sat_count, 0);
    chk("satclr_out_sat", out_sat, 1);
    drive(1'b1, 12'd4095, 1'b0, 1'b0, 1'b0);
    chk("sat_after_clr", sat_count, 1);

    // Reset in the middle of calibration
    drive(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b1, 12'd2048, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 12'd2048, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    chk("rstcal_busy", cal_busy, 0);
    chk("rstcal_baseline", baseline, 0);
    chk("rstcal_done", cal_done, 0);
    chk("rstcal_sat", sat_count, 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 12'd2048, 1'b0, 1'b0, 1'b0);
      if (cal_done || out_valid || cal_busy) bad++;
    end
    chk("rstcal_idle_quiet", bad, 0);

    // cal_start and baseline_load together: load wins
    baseline_in = 12'd500;
    drive(1'b0, 12'd0, 1'b1, 1'b1, 1'b0);
    chk("prio_baseline", baseline, 500);
    chk("prio_busy", cal_busy, 0);
    drive(1'b1, 12'd500, 1'b0, 1'b0, 1'b0);
    chk("prio_run_valid", out_valid, 1);
    chk("prio_run_out", out, 0);
    chk("prio_busy_after", cal_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
